// File: rtl/fir_circ_mem.sv
// Circular sample-history buffer feeding a serial FIR MAC.
// Each new sample triggers a newest-first replay of all DEPTH taps.
module fir_circ_mem #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 6
) (
    input  logic              clk_64x,
    input  logic              rst_n,
    input  logic              clk,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              drdy
);

    localparam int DEPTH = 1 << AWIDTH;

    logic              sync1;
    logic              sync2;
    logic              prev;
    logic              strobe;
    logic              busy;
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [AWIDTH:0]   cnt;
    logic [DWIDTH-1:0] mem [DEPTH];

    assign strobe = sync2 & ~prev;
    assign busy   = (cnt != '0);

    always_ff @(posedge clk_64x or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= clk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_64x or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (strobe) begin
            mem[wptr] <= din;
        end
    end

    // The tap read in a strobe cycle still sees the old word (read-before-write).
    always_ff @(posedge clk_64x or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            dout <= '0;
            drdy <= 1'b0;
        end else begin
            if (strobe) begin
                wptr <= wptr + 1'b1;
                rptr <= wptr;
                cnt  <= (AWIDTH + 1)'(DEPTH);
            end else if (busy) begin
                rptr <= rptr - 1'b1;
                cnt  <= cnt - 1'b1;
            end
            if (busy) begin
                dout <= mem[rptr];
                drdy <= 1'b1;
            end else begin
                drdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_circ_mem.sv
// Bench for fir_circ_mem: scoreboard of expected tap frames,
// checked every fast cycle for both drdy and dout.
`timescale 1ns/1ps
module tb_fir_circ_mem;

    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk_64x = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clk     = 1'b0;
    logic [DW-1:0] din     = '0;
    logic [DW-1:0] dout;
    logic          drdy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            mw       = 0;
    int            pend_w   = 0;
    int            start_in = -1;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_exp = '0;
    logic [DW-1:0] cap      [DEPTH];
    logic [DW-1:0] prev_cap [DEPTH];
    int            cap_len  = 0;
    int            prev_len = 0;

    fir_circ_mem #(.DWIDTH(DW), .AWIDTH(6)) dut (
        .clk_64x(clk_64x),
        .rst_n  (rst_n),
        .clk    (clk),
        .din    (din),
        .dout   (dout),
        .drdy   (drdy)
    );

    always #500 clk_64x = ~clk_64x;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        mw = 0;
    endtask

    // One clk period of `per` fast cycles, rising edge carrying v.
    task automatic sample(input logic [DW-1:0] v, input int per);
        @(negedge clk_64x);
        clk = 1'b1;
        din = v;
        model_mem[mw] = v;
        pend_w = mw;
        mw = (mw + 1) % DEPTH;
        start_in = 4;
        repeat (per / 2) @(negedge clk_64x);
        clk = 1'b0;
        repeat (per - per / 2 - 1) @(negedge clk_64x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_64x);
    endtask

    // Monitor: sync2 at edge 2, strobe write at edge 3, tap 0 after edge 4.
    always begin
        @(posedge clk_64x);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            start_in = -1;
            last_exp = '0;
            cap_len  = 0;
        end else begin
            if (start_in > 0) begin
                start_in--;
                if (start_in == 0) begin
                    start_in = -1;
                    prev_cap = cap;
                    prev_len = cap_len;
                    cap_len  = 0;
                    exp_q.delete();
                    for (int k = 0; k < DEPTH; k++)
                        exp_q.push_back(model_mem[(pend_w - k + DEPTH) % DEPTH]);
                end
            end
            check("drdy", 32'(drdy), 32'(exp_q.size() != 0));
            if (drdy && exp_q.size() != 0) begin
                last_exp = exp_q.pop_front();
                check("dout", 32'(dout), 32'(last_exp));
                if (cap_len < DEPTH) cap[cap_len] = dout;
                cap_len++;
            end else if (!drdy) begin
                check("hold", 32'(dout), 32'(last_exp));
            end
        end
    end

    initial begin
        model_clear();
        #1000;
        check("rst_drdy", 32'(drdy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        @(negedge clk_64x);
        rst_n = 1'b1;
        idle(10);

        sample(16'd5, 64);
        idle(80);
        check("first_len", 32'(cap_len), 32'd64);
        check("first_t0", 32'(cap[0]), 32'd5);
        check("first_t1", 32'(cap[1]), 32'd0);
        check("first_t63", 32'(cap[63]), 32'd0);

        for (int n = 0; n < 70; n++) sample(16'(n), 64);
        sample(16'd70, 64);
        check("wrap_len", 32'(prev_len), 32'd64);
        check("wrap_t0", 32'(prev_cap[0]), 32'd69);
        check("wrap_t1", 32'(prev_cap[1]), 32'd68);
        check("wrap_rbw", 32'(prev_cap[63]), 32'd6);

        sample(16'd100, 20);
        sample(16'd101, 64);
        check("early_len", 32'(prev_len), 32'd20);
        check("early_t0", 32'(prev_cap[0]), 32'd100);
        check("early_t1", 32'(prev_cap[1]), 32'd70);

        sample(16'd102, 30);
        @(negedge clk_64x);
        #200;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_drdy", 32'(drdy), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        sample(16'd7, 64);
        sample(16'd8, 64);
        idle(80);
        check("post_len", 32'(cap_len), 32'd64);
        check("post_t0", 32'(cap[0]), 32'd8);
        check("post_t1", 32'(cap[1]), 32'd7);
        check("post_t2", 32'(cap[2]), 32'd0);
        check("idle_drdy", 32'(drdy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
